// File: rtl/smac_seq_ctrl_if.sv
// Scheduler/array-control bundle for the serial MAC sequencer.
// The scheduler drives start/abort; the sequencer drives status, plane select and array strobes.
interface smac_seq_ctrl_if #(
    parameter int unsigned PW = 4
);
    localparam int unsigned JW = (PW > 1) ? $clog2(PW) : 1;

    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [JW-1:0] w_plane;
    logic          we_ar_mod;
    logic          se_ar_mod;
    logic          we_a;
    logic          we_w;
    logic          we_br;
    logic          we_neg;
    logic          MSB_a;
    logic          MSB_w;
    logic          we_ac1;
    logic          we_ac2;
    logic          cl_en_ac1;
    logic          cl_en_ac2;

    modport master (
        output start, abort,
        input  busy, done, w_plane,
        input  we_ar_mod, se_ar_mod, we_a, we_w, we_br, we_neg,
        input  MSB_a, MSB_w, we_ac1, we_ac2, cl_en_ac1, cl_en_ac2
    );

    modport slave (
        input  start, abort,
        output busy, done, w_plane,
        output we_ar_mod, se_ar_mod, we_a, we_w, we_br, we_neg,
        output MSB_a, MSB_w, we_ac1, we_ac2, cl_en_ac1, cl_en_ac2
    );
endinterface

// File: rtl/smac_seq_ctrl.sv
// Control sequencer for the serial MAC array: walks Pw weight bit-planes x Pa activation bits
// per job and emits registered load/shift/accumulate/negate/clear strobes.
module smac_seq_ctrl #(
    parameter int unsigned M  = 16,
    parameter int unsigned PA = 8,
    parameter int unsigned PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    smac_seq_ctrl_if.slave sif
);
    localparam int unsigned JW = (PW > 1) ? $clog2(PW) : 1;
    localparam int unsigned KW = $clog2(PA);

    if (M == 0 || PA < 2 || PW < 1) begin : g_param_err
        $error("smac_seq_ctrl: illegal parameters (need M>=1, PA>=2, PW>=1)");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT, S_DRAIN, S_BR, S_AC2, S_DONE
    } state_e;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [JW-1:0] w_plane;
        logic          we_ar_mod;
        logic          se_ar_mod;
        logic          we_a;
        logic          we_w;
        logic          we_br;
        logic          we_neg;
        logic          msb_a;
        logic          msb_w;
        logic          we_ac1;
        logic          we_ac2;
        logic          cl_en_ac1;
        logic          cl_en_ac2;
    } ctrl_t;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [JW-1:0] j_q, j_d;
    ctrl_t         out_q, out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            out_q   <= out_d;
        end
    end

    // Next state, then strobes decoded from the next state so the flops line up with state_q.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        out_d   = '0;

        if (sif.abort) begin
            state_d = S_IDLE;
            k_d     = '0;
            j_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    k_d = '0;
                    j_d = '0;
                    if (sif.start) state_d = S_LOAD;
                end
                S_LOAD: begin
                    k_d     = '0;
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (k_q == KW'(PA - 1)) begin
                        k_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                S_DRAIN: state_d = S_BR;
                S_BR:    state_d = S_AC2;
                S_AC2: begin
                    if (j_q == JW'(PW - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        j_d     = j_q + JW'(1);
                        state_d = S_LOAD;
                    end
                end
                S_DONE: begin
                    j_d     = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        unique case (state_d)
            S_LOAD: begin
                out_d.busy      = 1'b1;
                out_d.w_plane   = j_d;
                out_d.we_ar_mod = 1'b1;
                out_d.we_w      = 1'b1;
            end
            S_SHIFT: begin
                out_d.busy      = 1'b1;
                out_d.w_plane   = j_d;
                out_d.we_a      = 1'b1;
                out_d.se_ar_mod = (k_d != KW'(PA - 1));
                out_d.we_ac1    = (k_d != '0);
                out_d.cl_en_ac1 = (k_d == KW'(1));
            end
            S_DRAIN: begin
                out_d.busy    = 1'b1;
                out_d.w_plane = j_d;
                out_d.we_ac1  = 1'b1;
                out_d.msb_a   = 1'b1;
            end
            S_BR: begin
                out_d.busy    = 1'b1;
                out_d.w_plane = j_d;
                out_d.we_br   = 1'b1;
                out_d.we_neg  = (j_d == JW'(PW - 1));
                out_d.msb_w   = (j_d == JW'(PW - 1));
            end
            S_AC2: begin
                out_d.busy      = 1'b1;
                out_d.w_plane   = j_d;
                out_d.we_ac2    = 1'b1;
                out_d.cl_en_ac2 = (j_d == '0);
            end
            S_DONE:  out_d.done = 1'b1;
            default: out_d      = '0;
        endcase
    end

    assign sif.busy      = out_q.busy;
    assign sif.done      = out_q.done;
    assign sif.w_plane   = out_q.w_plane;
    assign sif.we_ar_mod = out_q.we_ar_mod;
    assign sif.se_ar_mod = out_q.se_ar_mod;
    assign sif.we_a      = out_q.we_a;
    assign sif.we_w      = out_q.we_w;
    assign sif.we_br     = out_q.we_br;
    assign sif.we_neg    = out_q.we_neg;
    assign sif.MSB_a     = out_q.msb_a;
    assign sif.MSB_w     = out_q.msb_w;
    assign sif.we_ac1    = out_q.we_ac1;
    assign sif.we_ac2    = out_q.we_ac2;
    assign sif.cl_en_ac1 = out_q.cl_en_ac1;
    assign sif.cl_en_ac2 = out_q.cl_en_ac2;
endmodule
